// File: rtl/pwm_level_ctrl.sv
// pwm_level_ctrl: drives the 3-bit select of the PWM level mux.
// Two raw push-buttons (up/down) are synchronised and debounced. Each clean press
// steps the level up or down, wrapping between 0 (off) and MAX_LEVEL.
// Optional auto-cycle timer: compile with `define PWM_AUTO_CYCLE_EN.
// Without that macro there is no timer and i_auto is ignored.
// A press is applied two edges after the raw level is first sampled, plus the debounce window.
// o_changed pulses in the same cycle that o_sel shows its new value.

module pwm_level_ctrl #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int MAX_LEVEL       = 4,
    parameter int AUTO_TICKS      = 50000000
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic       i_auto,
    output logic [2:0] o_sel,
    output logic       o_changed
);

    localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]      MAX_SEL = 3'(MAX_LEVEL);

    // Button index 0 = up, 1 = down throughout.
    logic [1:0]            btn_raw;
    logic [1:0]            sync1_q;
    logic [1:0]            sync2_q;
    logic [1:0]            stable_q;
    logic [1:0]            stable_d;
    logic [1:0]            press_q;
    logic [1:0]            press_d;
    logic [1:0][DB_W-1:0]  db_cnt_q;
    logic [1:0][DB_W-1:0]  db_cnt_d;

    logic                  up_evt;
    logic                  down_evt;
    logic                  auto_evt;

    logic [2:0]            sel_q;
    logic [2:0]            sel_d;
    logic                  changed_q;
    logic                  changed_d;

    assign btn_raw = {i_btn_down, i_btn_up};

    // Two-flop synchroniser per button; the raw inputs are asynchronous to i_clk.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive cycles where the synced level disagrees with the
    // accepted level. Any agreement restarts the count. The accepted level flips once
    // the disagreement has lasted DEBOUNCE_CYCLES cycles.
    // Only a 0->1 flip raises a press; releases are silent.
    always_comb begin
        stable_d = stable_q;
        press_d  = '0;
        db_cnt_d = '0;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] != stable_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    stable_d[b] = sync2_q[b];
                    press_d[b]  = sync2_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + 1'b1;
                end
            end
        end
    end

    // Debounce state and the registered one-cycle press pulses.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            stable_q <= '0;
            press_q  <= '0;
            db_cnt_q <= '0;
        end else begin
            stable_q <= stable_d;
            press_q  <= press_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign up_evt   = press_q[0];
    assign down_evt = press_q[1];

`ifdef PWM_AUTO_CYCLE_EN
    localparam int              AT_W    = (AUTO_TICKS > 1) ? $clog2(AUTO_TICKS) : 1;
    localparam logic [AT_W-1:0] AT_LAST = AT_W'(AUTO_TICKS - 1);

    logic            btn_evt;
    logic [AT_W-1:0] auto_tmr_q;
    logic [AT_W-1:0] auto_tmr_d;

    assign btn_evt = up_evt | down_evt;

    // Auto timer: runs only while i_auto is high. Any button event restarts it,
    // and that event also takes priority over an auto step in the same cycle.
    // The auto step fires in the cycle the timer sits at its last count.
    always_comb begin
        auto_evt   = 1'b0;
        auto_tmr_d = '0;
        if (i_auto && !btn_evt) begin
            if (auto_tmr_q == AT_LAST) begin
                auto_evt = 1'b1;
            end else begin
                auto_tmr_d = auto_tmr_q + 1'b1;
            end
        end
    end

    // Auto timer register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            auto_tmr_q <= '0;
        end else begin
            auto_tmr_q <= auto_tmr_d;
        end
    end
`else
    logic unused_auto;

    assign auto_evt    = 1'b0;
    assign unused_auto = i_auto;
`endif

    // Level stepping with wrap. Simultaneous up and down cancel out.
    // An auto step counts as an up and is used only when no button event is present.
    always_comb begin
        sel_d = sel_q;
        if (up_evt && !down_evt) begin
            sel_d = (sel_q == MAX_SEL) ? 3'd0 : sel_q + 3'd1;
        end else if (down_evt && !up_evt) begin
            sel_d = (sel_q == 3'd0) ? MAX_SEL : sel_q - 3'd1;
        end else if (!up_evt && !down_evt && auto_evt) begin
            sel_d = (sel_q == MAX_SEL) ? 3'd0 : sel_q + 3'd1;
        end
        changed_d = (sel_d != sel_q);
    end

    // Select register and its change pulse, updated on the same edge.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            sel_q     <= 3'd0;
            changed_q <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            changed_q <= changed_d;
        end
    end

    assign o_sel     = sel_q;
    assign o_changed = changed_q;

endmodule
